// File: rtl/line_collector_pkg.sv
// Shared types and sizes for the line collector: line width, frame depth, FSM states.
package line_collector_pkg;

    localparam int LINE_WIDTH  = 25;
    localparam int FRAME_LINES = 64;
    localparam int IDX_W       = 6;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    typedef logic [LINE_WIDTH-1:0] line_t;

endpackage

// File: rtl/line_collector_if.sv
// Producer strobe and consumer drain bundle. The collector uses the slave view.
// out_parity only exists when LINE_COLLECTOR_PARITY_EN is defined.
interface line_collector_if
    import line_collector_pkg::*;
#(
    parameter int WIDTH = LINE_WIDTH
);
    logic             write_enable;
    logic [WIDTH-1:0] write_value;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_line;
    logic [IDX_W-1:0] out_index;
    logic             frame_done;
    logic             overflow;
`ifdef LINE_COLLECTOR_PARITY_EN
    logic             out_parity;

    modport master (
        output write_enable, write_value, out_ready,
        input  out_valid, out_line, out_index, frame_done, overflow, out_parity
    );
    modport slave (
        input  write_enable, write_value, out_ready,
        output out_valid, out_line, out_index, frame_done, overflow, out_parity
    );
`else
    modport master (
        output write_enable, write_value, out_ready,
        input  out_valid, out_line, out_index, frame_done, overflow
    );
    modport slave (
        input  write_enable, write_value, out_ready,
        output out_valid, out_line, out_index, frame_done, overflow
    );
`endif
endinterface

// File: rtl/line_buffer_ram.sv
// Frame storage: LINES x WIDTH, one synchronous write port, one asynchronous read port.
// Latency: write visible the cycle after we; read is combinational. No backpressure.
// Contents are deliberately not reset.
module line_buffer_ram #(
    parameter int LINES = 64,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             we,
    input  logic [5:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [5:0]       raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/line_collector.sv
// Collects LINES lines on write_enable rising edges, then drains them in order with valid/ready.
// Latency: first line valid one cycle after DRAIN entry; one line per cycle while out_ready is high.
// Backpressure: out_ready low holds the line; strobes while draining are dropped and set sticky overflow.
// Optional LINE_COLLECTOR_PARITY_EN adds out_parity.
module line_collector
    import line_collector_pkg::*;
#(
    parameter int LINES = FRAME_LINES,
    parameter int WIDTH = LINE_WIDTH
) (
    input logic             clk,
    input logic             rst,
    line_collector_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LINES - 1);

    state_t           state, state_nxt;
    logic             we_q;
    logic             armed;
    logic             capture;
    logic [IDX_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [IDX_W-1:0] rd_ptr, rd_ptr_nxt;
    logic             ram_we;
    logic [IDX_W-1:0] ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic             out_valid_q, valid_nxt;
    logic [WIDTH-1:0] out_line_q, line_nxt;
    logic [IDX_W-1:0] out_index_q, index_nxt;
    logic             frame_done_q, done_nxt;
    logic             overflow_q, ovf_nxt;

    // armed stays low until write_enable is seen low after reset, so a strobe
    // held high across reset release cannot look like a fresh edge.
    assign capture = bus.write_enable & ~we_q & armed;

    // While a line is presented, the only useful next line is rd_ptr+1.
    assign ram_raddr = out_valid_q ? rd_ptr + 6'd1 : rd_ptr;

    line_buffer_ram #(
        .LINES (LINES),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (bus.write_value),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        ram_we     = 1'b0;
        valid_nxt  = out_valid_q;
        line_nxt   = out_line_q;
        index_nxt  = out_index_q;
        done_nxt   = 1'b0;
        ovf_nxt    = overflow_q;
        case (state)
            IDLE, FILL: begin
                if (capture) begin
                    ram_we = 1'b1;
                    if (wr_ptr == LAST) begin
                        wr_ptr_nxt = '0;
                        state_nxt  = DRAIN;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 6'd1;
                        state_nxt  = FILL;
                    end
                end
            end
            DRAIN: begin
                if (capture) begin
                    ovf_nxt = 1'b1;
                end
                if (!out_valid_q) begin
                    valid_nxt = 1'b1;
                    line_nxt  = ram_rdata;
                    index_nxt = rd_ptr;
                end else if (bus.out_ready) begin
                    if (rd_ptr == LAST) begin
                        rd_ptr_nxt = '0;
                        state_nxt  = IDLE;
                        valid_nxt  = 1'b0;
                        line_nxt   = '0;
                        index_nxt  = '0;
                        done_nxt   = 1'b1;
                    end else begin
                        rd_ptr_nxt = rd_ptr + 6'd1;
                        line_nxt   = ram_rdata;
                        index_nxt  = rd_ptr + 6'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            armed        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_valid_q  <= 1'b0;
            out_line_q   <= '0;
            out_index_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            we_q         <= bus.write_enable;
            armed        <= armed | ~bus.write_enable;
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            out_valid_q  <= valid_nxt;
            out_line_q   <= line_nxt;
            out_index_q  <= index_nxt;
            frame_done_q <= done_nxt;
            overflow_q   <= ovf_nxt;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_line   = out_line_q;
    assign bus.out_index  = out_index_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
`ifdef LINE_COLLECTOR_PARITY_EN
    assign bus.out_parity = ^out_line_q;
`endif
endmodule

// File: tb/tb_line_collector.sv
// Bench for line_collector: table-driven frame vectors, corner sequences and random traffic
// checked every cycle against a queue-based frame model.
module tb_line_collector;
    import line_collector_pkg::*;

    localparam int N = FRAME_LINES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    line_collector_if #(.WIDTH(LINE_WIDTH)) bus();

    line_collector #(
        .LINES (N),
        .WIDTH (LINE_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: lines captured so far, and the frame being drained.
    bit    draining;
    bit    drv_prev;
    bit    exp_done;
    bit    exp_ovf;
    int    drain_age;
    int    acc_n;
    line_t coll[$];
    line_t frame[$];

    // Observations of the current drain.
    int    vcnt;
    int    acc_cnt;
    bit    seen_done;
    line_t first_acc;
    line_t last_acc;

    typedef struct {
        int    mult;
        int    add;
        int    hold;
        int    mode;
        line_t exp_first;
        line_t exp_last;
        int    exp_vcyc;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input bit we, input line_t val, input bit rdy);
        bit               ev;
        line_t            el;
        logic [IDX_W-1:0] ei;
        bit               cap;
        bit               acc;
        ev = draining && drain_age >= 1;
        el = ev ? frame[acc_n] : '0;
        ei = ev ? IDX_W'(acc_n) : '0;
        check("out_valid", 32'(bus.out_valid), 32'(ev));
        check("out_line", 32'(bus.out_line), 32'(el));
        check("out_index", 32'(bus.out_index), 32'(ei));
        check("frame_done", 32'(bus.frame_done), 32'(exp_done));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));
`ifdef LINE_COLLECTOR_PARITY_EN
        check("out_parity", 32'(bus.out_parity), 32'(^el));
`endif
        if (bus.out_valid) vcnt++;
        if (bus.out_valid && rdy) begin
            if (acc_cnt == 0) first_acc = bus.out_line;
            last_acc = bus.out_line;
            acc_cnt++;
        end
        if (bus.frame_done) seen_done = 1'b1;

        bus.write_enable = we;
        bus.write_value  = val;
        bus.out_ready    = rdy;
        cap      = we && !drv_prev;
        drv_prev = we;
        acc      = ev && rdy;
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        if (draining) begin
            if (cap) exp_ovf = 1'b1;
            if (acc) begin
                acc_n++;
                if (acc_n == N) begin
                    draining = 1'b0;
                    exp_done = 1'b1;
                end
            end
            drain_age++;
        end else if (cap) begin
            coll.push_back(val);
            if (coll.size() == N) begin
                frame     = coll;
                coll.delete();
                draining  = 1'b1;
                drain_age = 0;
                acc_n     = 0;
            end
        end
    endtask

    // Reset mid-cycle; outputs must clear at once. A level high at release is not an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_line", 32'(bus.out_line), 32'd0);
        check("rst_index", 32'(bus.out_index), 32'd0);
        check("rst_done", 32'(bus.frame_done), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        draining = 1'b0;
        coll.delete();
        frame.delete();
        exp_done = 1'b0;
        exp_ovf  = 1'b0;
        drv_prev = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_lines(input int n, input int mult, input int add, input int hold);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < n; i++) begin
            for (int h = 0; h < hold; h++) step(1'b1, line_t'(i * mult + add), 1'b0);
            step(1'b0, '0, 1'b0);
        end
    endtask

    // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating; else random.
    // A single-cycle strobe is issued when the valid-cycle count hits strobe_a or strobe_b.
    task automatic drain(input int mode, input int strobe_a, input int strobe_b);
        int guard;
        bit rdy;
        bit we;
        vcnt      = 0;
        acc_cnt   = 0;
        seen_done = 1'b0;
        guard     = 0;
        while (!seen_done && guard < 1000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (vcnt % 4 == 0) || (vcnt % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            we = (vcnt == strobe_a) || (vcnt == strobe_b);
            step(we, 25'h0000001, rdy);
            guard++;
        end
        check("drain_done", 32'(seen_done), 32'd1);
    endtask

    initial begin
        vecs[0] = '{mult: 3, add: 0,     hold: 1, mode: 0, exp_first: 25'd0,     exp_last: 25'd189,   exp_vcyc: 64};
        vecs[1] = '{mult: 1, add: 'h100, hold: 5, mode: 1, exp_first: 25'h100,   exp_last: 25'h13F,   exp_vcyc: 128};
        vecs[2] = '{mult: 7, add: 1,     hold: 2, mode: 0, exp_first: 25'd1,     exp_last: 25'd442,   exp_vcyc: 64};
        vecs[3] = '{mult: 4, add: 3,     hold: 1, mode: 1, exp_first: 25'd3,     exp_last: 25'd255,   exp_vcyc: 128};

        bus.write_enable = 1'b0;
        bus.write_value  = '0;
        bus.out_ready    = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            do_reset();
            send_lines(N, vecs[v].mult, vecs[v].add, vecs[v].hold);
            drain(vecs[v].mode, -1, -1);
            check("vec_first", 32'(first_acc), 32'(vecs[v].exp_first));
            check("vec_last", 32'(last_acc), 32'(vecs[v].exp_last));
            check("vec_valid_cycles", 32'(vcnt), 32'(vecs[v].exp_vcyc));
        end

        // Held strobe captures exactly once.
        do_reset();
        step(1'b0, '0, 1'b0);
        for (int h = 0; h < 5; h++) step(1'b1, 25'h1ABCDEF, 1'b0);
        send_lines(N - 1, 1, 1, 1);
        drain(0, -1, -1);
        check("held_first", 32'(first_acc), 32'h01ABCDEF);
        check("held_count", 32'(acc_cnt), 32'(N));
        check("held_last", 32'(last_acc), 32'(N - 1));

        // Strobes during drain and on the final acceptance cycle are dropped; overflow sticks.
        do_reset();
        send_lines(N, 5, 0, 1);
        drain(0, 10, N - 1);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_data_last", 32'(last_acc), 32'((N - 1) * 5));
        send_lines(N, 2, 9, 1);
        drain(1, -1, -1);
        check("ovf_persist", 32'(bus.overflow), 32'd1);
        check("ovf_next_first", 32'(first_acc), 32'd9);
        check("ovf_next_last", 32'(last_acc), 32'((N - 1) * 2 + 9));

        // Reset after 30 lines abandons the partial frame.
        do_reset();
        send_lines(30, 11, 0, 1);
        do_reset();
        send_lines(N, 13, 5, 1);
        drain(0, -1, -1);
        check("abort_first", 32'(first_acc), 32'd5);
        check("abort_last", 32'(last_acc), 32'((N - 1) * 13 + 5));

        // write_enable high across reset release is not a capture.
        bus.write_enable = 1'b1;
        bus.write_value  = 25'h55;
        do_reset();
        for (int h = 0; h < 3; h++) step(1'b1, 25'h55, 1'b0);
        send_lines(N, 1, 'h200, 1);
        drain(0, -1, -1);
        check("rel_first", 32'(first_acc), 32'h200);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            step(1'($urandom_range(0, 1)), line_t'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_collector.md
LINE_COLLECTOR -- requirements
Module: line_collector

Interface
REQ-001 SHALL have parameter LINES, default 64, number of 25-bit lines per frame.
REQ-002 SHALL have parameter WIDTH, default 25, bits per line (one 5x5 plane slice).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port write_enable  input  1  line strobe from permutation_func.
REQ-006 SHALL have port write_value  input  WIDTH  line data from permutation_func.
REQ-007 SHALL have port out_valid  output  1  out_line/out_index valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the line when high with out_valid.
REQ-009 SHALL have port out_line  output  WIDTH  buffered line being drained.
REQ-010 SHALL have port out_index  output  6  index 0..LINES-1 of out_line.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after the last line is accepted.
REQ-012 SHALL have port overflow  output  1  sticky: a line arrived while draining.

Function
REQ-013 SHALL register write_enable each cycle and detect a capture event as registered-low and current-high (rising edge); a held-high strobe SHALL capture exactly once.
REQ-014 SHALL write write_value, sampled in the capture cycle, into buffer[wr_ptr], then increment wr_ptr (6 bits).
REQ-015 SHALL implement FSM states IDLE, FILL, DRAIN.
REQ-016 IDLE -> FILL on the first capture event (that line stored at index 0).
REQ-017 FILL -> DRAIN on the cycle after the capture that stores index LINES-1; wr_ptr SHALL wrap to 0.
REQ-018 In DRAIN, out_valid SHALL be 1 and out_line = buffer[rd_ptr], out_index = rd_ptr, stable while out_ready = 0.
REQ-019 rd_ptr SHALL increment only on out_valid & out_ready; throughput one line per cycle when out_ready is held high.
REQ-020 Acceptance of index LINES-1 SHALL move DRAIN -> IDLE, pulse frame_done for exactly one cycle and wrap rd_ptr to 0.
REQ-021 A capture event in DRAIN SHALL be discarded (buffer unchanged) and SHALL set overflow; overflow clears only on rst.
REQ-022 A capture event in the same cycle as the DRAIN -> IDLE transition SHALL be discarded and set overflow.
REQ-023 out_valid SHALL be 0 in IDLE and FILL; out_line/out_index SHALL be 0 whenever out_valid = 0.
REQ-024 Latency: the first line SHALL be presented one cycle after the DRAIN entry transition.

Reset
REQ-025 rst high SHALL immediately force state IDLE, wr_ptr = 0, rd_ptr = 0, edge register = 0, out_valid = 0, out_line = 0, out_index = 0, frame_done = 0, overflow = 0.
REQ-026 Buffer contents SHALL NOT be reset; reset mid-FILL or mid-DRAIN SHALL abandon the frame, with no frame_done.
REQ-027 A write_enable held high across reset release SHALL NOT create a capture event until it goes low and high again.

Configuration
REQ-028 With LINE_COLLECTOR_PARITY_EN defined, SHALL add output out_parity (1 bit) = XOR of out_line bits, valid with out_valid, 0 otherwise and after reset.
REQ-029 Without LINE_COLLECTOR_PARITY_EN, out_parity SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-030 Shared package SHALL hold LINE_WIDTH = 25, FRAME_LINES = 64, the state enum type {IDLE, FILL, DRAIN} and the line typedef (25-bit vector).
REQ-031 One sub-module, line_buffer_ram (LINES x WIDTH, one synchronous write port, one asynchronous read port), SHALL hold the storage.

Verification
REQ-032 Reset then 64 single-cycle strobes with write_value = index*3 -> DRAIN with out_ready = 1 yields out_line 0,3,...,189 on indices 0..63 in 64 consecutive cycles, then one frame_done pulse.
REQ-033 Strobe held high for 5 cycles with value 25'h1ABCDEF -> exactly one line captured, wr_ptr = 1.
REQ-034 Full frame, out_ready toggled 1,0,0,1 repeating -> out_line/out_index hold during stalls; all 64 lines delivered in order, no duplicates.
REQ-035 Strobe during DRAIN with value 25'h0000001 -> overflow = 1, drained data unchanged, overflow persists until rst.
REQ-036 rst asserted after 30 captured lines -> all outputs 0 next sample; new frame of 64 lines drains starting at index 0 with new data.
REQ-037 With LINE_COLLECTOR_PARITY_EN, line 25'h0000007 -> out_parity = 1; line 25'h0000003 -> out_parity = 0.
